// File: rtl/module_encoder.sv
// module_encoder: emits one TBM module readout as a framed 4-bit nibble stream with handshaked pixel source
module module_encoder #(
  parameter int IDLE_GAP = 4
) (
  input  logic        clk80,
  input  logic        reset,
  input  logic        davail,
  input  logic        start,
  input  logic [7:0]  event_no,
  input  logic [7:0]  hdr_stat,
  input  logic [7:0]  trl_stat,
  input  logic [3:0]  roc_count,
  input  logic [1:0]  roc_bits,
  input  logic        src_valid,
  input  logic        src_eor,
  input  logic [23:0] src_data,
  output logic        src_ready,
  output logic [3:0]  dout,
  output logic        dvalid,
  output logic        busy,
  output logic        underrun,
  output logic        frame_done
);
  typedef enum logic [2:0] {IDLE, THDR, RHDR, PIX, TTRL, GAP} state_t;
  localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);
  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [3:0]  dout_q, dout_d;
  logic        dvalid_q, busy_q, busy_d, underrun_q, underrun_d, frame_done_q, frame_done_d;
  logic [3:0]  cnt_q, cnt_d, rc_q, rc_d;
  logic [1:0]  rb_q, rb_d;
  logic [7:0]  ev_q, ev_d, hs_q, hs_d, ts_q, ts_d;
  logic [23:0] hold_q, hold_d;
  logic [31:0] w;
  logic [7:0]  last;
  logic [2:0]  sh;
  logic [3:0]  nib;
  logic        last_hit, more;
  // Nibble table of the current state: right-aligned word plus index of its last nibble
  always_comb begin
    w = 32'hFFFF_FFFF;
    last = 8'd0;
    unique case (state_q)
      THDR: begin w = {4'hF, 12'h7FC, ev_q, hs_q}; last = 8'd6; end
      RHDR: begin w = {20'hFFFFF, 8'h7F, 2'b10, rb_q}; last = 8'd2; end
      PIX:  begin w = {8'hFF, hold_q}; last = 8'd5; end
      TTRL: begin w = {4'hF, 12'h7FE, ts_q[7] | underrun_q, ts_q[6:0], 8'h00}; last = 8'd6; end
      GAP:  last = GAP_LAST;
      default: ;
    endcase
    sh = last[2:0] - n_q[2:0];
    nib = w[{sh, 2'b00} +: 4];
    last_hit = (n_q == last);
    more = ({1'b0, cnt_q} + 5'd1) < {1'b0, rc_q};
  end
  // Frame sequencing: start acceptance, per-davail advance and the pop-point decisions
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    dout_d = dout_q;
    busy_d = busy_q;
    underrun_d = underrun_q;
    frame_done_d = 1'b0;
    cnt_d = cnt_q;
    rc_d = rc_q;
    rb_d = rb_q;
    ev_d = ev_q;
    hs_d = hs_q;
    ts_d = ts_q;
    hold_d = hold_q;
    src_ready = 1'b0;
    if (start && !busy_q) begin
      state_d = THDR;
      n_d = 8'd0;
      busy_d = 1'b1;
      underrun_d = 1'b0;
      cnt_d = 4'd0;
      rc_d = roc_count;
      rb_d = roc_bits;
      ev_d = event_no;
      hs_d = hdr_stat;
      ts_d = trl_stat;
    end else if (davail && state_q != IDLE) begin
      dout_d = nib;
      n_d = last_hit ? 8'd0 : n_q + 8'd1;
      if (last_hit) begin
        unique case (state_q)
          THDR: state_d = (rc_q != 4'd0) ? RHDR : TTRL;
          RHDR, PIX: begin
            src_ready = src_valid && !reset;
            underrun_d = underrun_q | ~src_valid;
            hold_d = (src_valid && !src_eor) ? src_data : hold_q;
            cnt_d = (src_valid && src_eor) ? cnt_q + 4'd1 : cnt_q;
            state_d = !src_valid ? TTRL : !src_eor ? PIX : more ? RHDR : TTRL;
          end
          TTRL: begin state_d = GAP; frame_done_d = 1'b1; end
          GAP:  begin state_d = IDLE; busy_d = 1'b0; end
          default: ;
        endcase
      end
    end
  end
  // State and registered outputs
  always_ff @(posedge clk80) begin
    if (reset) begin
      state_q <= IDLE;
      n_q <= 8'd0;
      dout_q <= 4'hF;
      dvalid_q <= 1'b0;
      busy_q <= 1'b0;
      underrun_q <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q <= 4'd0;
      rc_q <= 4'd0;
      rb_q <= 2'd0;
      ev_q <= 8'd0;
      hs_q <= 8'd0;
      ts_q <= 8'd0;
      hold_q <= 24'd0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      dout_q <= dout_d;
      dvalid_q <= davail;
      busy_q <= busy_d;
      underrun_q <= underrun_d;
      frame_done_q <= frame_done_d;
      cnt_q <= cnt_d;
      rc_q <= rc_d;
      rb_q <= rb_d;
      ev_q <= ev_d;
      hs_q <= hs_d;
      ts_q <= ts_d;
      hold_q <= hold_d;
    end
  end
  assign dout = dout_q;
  assign dvalid = dvalid_q;
  assign busy = busy_q;
  assign underrun = underrun_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_module_encoder.sv
// tb_module_encoder: table-driven frame vectors plus reset/abort sequence for module_encoder
module tb_module_encoder;
  logic        clk80, reset, davail, start;
  logic [7:0]  event_no, hdr_stat, trl_stat;
  logic [3:0]  roc_count;
  logic [1:0]  roc_bits;
  logic        src_valid, src_eor;
  logic [23:0] src_data;
  logic        src_ready, dvalid, busy, underrun, frame_done;
  logic [3:0]  dout;

  module_encoder #(.IDLE_GAP(4)) dut (
    .clk80(clk80), .reset(reset), .davail(davail), .start(start),
    .event_no(event_no), .hdr_stat(hdr_stat), .trl_stat(trl_stat),
    .roc_count(roc_count), .roc_bits(roc_bits),
    .src_valid(src_valid), .src_eor(src_eor), .src_data(src_data),
    .src_ready(src_ready), .dout(dout), .dvalid(dvalid), .busy(busy),
    .underrun(underrun), .frame_done(frame_done)
  );

  initial clk80 = 1'b0;
  always #5 clk80 = ~clk80;

  typedef struct {
    logic [7:0]       ev, hs, ts;
    logic [3:0]       rc;
    logic [1:0]       rb;
    int               per;
    bit               t5;
    logic [3:0][24:0] src;
    int               nsrc;
    logic [159:0]     stream;
    int               len;
    int               pops;
    logic             ur;
  } vec_t;

  localparam logic [24:0] EOR = 25'h1000000;
  vec_t tv[6];
  logic [24:0] q[$];
  int tests = 0, fails = 0, pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    src_valid = q.size() > 0;
    src_eor = (q.size() > 0) ? q[0][24] : 1'b0;
    src_data = (q.size() > 0) ? q[0][23:0] : 24'd0;
  endtask

  task automatic step();
    logic p;
    @(negedge clk80);
    p = src_ready;
    @(posedge clk80);
    #1;
    if (p && q.size() > 0) begin
      q.delete(0);
      pops++;
    end
    drive_src();
  endtask

  function automatic vec_t mk(input logic [7:0] ev, hs, ts, input logic [3:0] rc, input logic [1:0] rb,
                              input int per, input bit t5, input logic [159:0] stream, input int len,
                              input int npops, input logic ur);
    vec_t v;
    v.ev = ev; v.hs = hs; v.ts = ts; v.rc = rc; v.rb = rb; v.per = per; v.t5 = t5;
    v.src = '0; v.nsrc = 0; v.stream = stream; v.len = len; v.pops = npops; v.ur = ur;
    return v;
  endfunction

  task automatic run_vector(input int i);
    vec_t v;
    int k, cyc, fd_at, fd_n;
    v = tv[i];
    q.delete();
    for (int j = 0; j < v.nsrc; j++) q.push_back(v.src[j]);
    drive_src();
    event_no = v.ev; hdr_stat = v.hs; trl_stat = v.ts; roc_count = v.rc; roc_bits = v.rb;
    pops = 0;
    davail = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", i), 32'(busy), 32'd1);
    chk($sformatf("v%0d underrun_cleared", i), 32'(underrun), 32'd0);
    k = 0; cyc = 1; fd_at = -1; fd_n = 0;
    while (k < v.len && cyc < 400) begin
      davail = (cyc % v.per) == 0;
      start = v.t5 && (k == 2 || frame_done);
      step();
      cyc++;
      if (dvalid) begin
        chk($sformatf("v%0d nibble%0d", i, k), 32'(dout), 32'(v.stream[4*(v.len-1-k) +: 4]));
        if (frame_done) begin fd_n++; fd_at = k; end
        k++;
      end
    end
    start = 1'b0;
    if (k < v.len) begin
      fails++; tests++;
      $display("FAIL v%0d timeout: got %0d nibbles expected %0d", i, k, v.len);
    end
    chk($sformatf("v%0d frame_done_index", i), 32'(fd_at), 32'(v.len - 5));
    chk($sformatf("v%0d frame_done_count", i), 32'(fd_n), 32'd1);
    chk($sformatf("v%0d pops", i), 32'(pops), 32'(v.pops));
    chk($sformatf("v%0d underrun", i), 32'(underrun), 32'(v.ur));
    chk($sformatf("v%0d busy_end", i), 32'(busy), 32'd0);
  endtask

  initial begin
    int k, cyc;
    tv[0] = mk(8'hA5, 8'h3C, 8'h01, 4'd0, 2'b00, 1, 0, 160'h7FCA53C_7FE0100_FFFF, 18, 0, 1'b0);
    tv[1] = mk(8'h11, 8'h22, 8'h33, 4'd2, 2'b01, 1, 0, 160'h7FC1122_7F9_123456_7F9_7FE3300_FFFF, 30, 3, 1'b0);
    tv[1].src[0] = 25'h0123456; tv[1].src[1] = EOR; tv[1].src[2] = EOR; tv[1].nsrc = 3;
    tv[2] = mk(8'hA5, 8'h3C, 8'h01, 4'd0, 2'b00, 4, 0, 160'h7FCA53C_7FE0100_FFFF, 18, 0, 1'b0);
    tv[3] = mk(8'h00, 8'h00, 8'h00, 4'd1, 2'b01, 1, 0, 160'h7FC0000_7F9_7FE8000_FFFF, 21, 0, 1'b1);
    tv[4] = mk(8'h5A, 8'hC3, 8'hC2, 4'd0, 2'b00, 1, 1, 160'h7FC5AC3_7FEC200_FFFF, 18, 0, 1'b0);
    tv[5] = mk(8'h01, 8'h02, 8'h03, 4'd1, 2'b10, 2, 0, 160'h7FC0102_7FA_0A0B0C_7FE0300_FFFF, 27, 2, 1'b0);
    tv[5].src[0] = 25'h00A0B0C; tv[5].src[1] = EOR; tv[5].nsrc = 2;
    reset = 1'b1; davail = 1'b0; start = 1'b0;
    event_no = 8'd0; hdr_stat = 8'd0; trl_stat = 8'd0; roc_count = 4'd0; roc_bits = 2'd0;
    q.delete();
    drive_src();
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset dout", 32'(dout), 32'hF);
    chk("reset dvalid", 32'(dvalid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset src_ready", 32'(src_ready), 32'd0);
    for (int i = 0; i < 6; i++) run_vector(i);
    q.delete();
    q.push_back(25'h0ABCDEF);
    q.push_back(EOR);
    drive_src();
    event_no = 8'h00; hdr_stat = 8'h00; roc_count = 4'd1; roc_bits = 2'b01;
    davail = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    pops = 0;
    k = 0; cyc = 0;
    while (k < 13 && cyc < 100) begin
      step();
      cyc++;
      if (dvalid) k++;
    end
    chk("abort third pixel nibble", 32'(dout), 32'hC);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort dout", 32'(dout), 32'hF);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort dvalid", 32'(dvalid), 32'd0);
    chk("abort src_ready", 32'(src_ready), 32'd0);
    repeat (20) step();
    chk("abort pops", 32'(pops), 32'd1);
    chk("abort busy_later", 32'(busy), 32'd0);
    chk("abort dout_later", 32'(dout), 32'hF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
